// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shifter built around one single-step 16-bit shifter.
// Codes: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.

module shift_step (
    input  logic [1:0]  op,
    input  logic [15:0] a,
    output logic [15:0] y
);
    always_comb begin
        unique case (op)
            2'b01:   y = {a[14:0], 1'b0};
            2'b10:   y = {1'b0, a[15:1]};
            2'b11:   y = {a[15], a[15:1]};
            default: y = a;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [15:0]      in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [1:0]         op_q, op_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        step_y;

    shift_step u_step (
        .op (op_q),
        .a  (acc_q),
        .y  (step_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            // DONE accepts a new start exactly like IDLE so back-to-back ops need no bubble
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = in;
                    op_d    = op;
                    cnt_d   = amount;
                    state_d = (amount == '0 || op == 2'b00) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = step_y;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed plan plus randomized ops
// compared against an arithmetic reference model.

module tb_shift_sequencer;
    localparam int unsigned AMT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
    logic [15:0]      in;
    logic             busy;
    logic             done;
    logic [15:0]      result;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .in      (in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole N-step shift computed directly with shift operators.
    function automatic logic [15:0] model(input logic [1:0] o, input int unsigned n, input logic [15:0] d);
        logic signed [15:0] s;
        s = d;
        case (o)
            2'b01:   return (n >= 16) ? 16'h0000 : (d << n);
            2'b10:   return (n >= 16) ? 16'h0000 : (d >> n);
            2'b11:   return (n >= 16) ? (d[15] ? 16'hFFFF : 16'h0000) : 16'(s >>> n);
            default: return d;
        endcase
    endfunction

    function automatic int unsigned steps(input logic [1:0] o, input int unsigned a);
        return (o == 2'b00) ? 0 : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        op     = 2'($urandom);
        amount = AMT_W'($urandom);
        in     = 16'($urandom);
    endtask

    // Presents a request ahead of the accepting edge (end of cycle 0).
    task automatic launch(input logic [1:0] o, input int unsigned a, input logic [15:0] d);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        amount = AMT_W'(a);
        in     = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
    endtask

    // Follows cycles 1..N+1; optionally pulses a stray start in cycle poke.
    task automatic track(input string tag, input logic [1:0] o, input int unsigned a,
                         input logic [15:0] d, input int poke);
        int unsigned n;
        n = steps(o, a);
        for (int c = 1; c <= int'(n) + 1; c++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'(c <= int'(n)));
            chk({tag, "_done"}, 32'(done), 32'(c == int'(n) + 1));
            if (c == int'(n) + 1)
                chk({tag, "_result"}, 32'(result), 32'(model(o, a, d)));
            if (c == poke) begin
                start = 1'b1;
                in    = 16'hFFFF;
                op    = 2'b10;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        int unsigned ra;
        logic [15:0] rd;
        logic [15:0] held;

        reset_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        amount  = '0;
        in      = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        reset_n = 1'b1;

        launch(2'b01, 4, 16'h0001);
        track("lsl4", 2'b01, 4, 16'h0001, 0);
        chk("lsl4_val", 32'(result), 32'h0010);
        @(negedge clk);
        chk("lsl4_after_done", 32'(done), 0);
        chk("lsl4_hold", 32'(result), 32'h0010);

        launch(2'b11, 3, 16'h8000);
        track("asr3", 2'b11, 3, 16'h8000, 0);
        chk("asr3_val", 32'(result), 32'hF000);
        launch(2'b11, 15, 16'h4000);
        track("asr15", 2'b11, 15, 16'h4000, 0);
        chk("asr15_val", 32'(result), 32'h0000);

        launch(2'b10, 15, 16'h8001);
        track("lsr15", 2'b10, 15, 16'h8001, 0);
        chk("lsr15_val", 32'(result), 32'h0001);
        launch(2'b00, 7, 16'hBEEF);
        track("nop", 2'b00, 7, 16'hBEEF, 0);
        chk("nop_val", 32'(result), 32'hBEEF);

        // Back-to-back: start held in the DONE cycle of a zero-amount op.
        launch(2'b01, 0, 16'h1234);
        @(negedge clk);
        chk("b2b_first_done", 32'(done), 1);
        chk("b2b_first_result", 32'(result), 32'h1234);
        start  = 1'b1;
        op     = 2'b01;
        amount = AMT_W'(1);
        in     = 16'h00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        track("b2b_second", 2'b01, 1, 16'h00FF, 0);
        chk("b2b_second_val", 32'(result), 32'h01FE);

        launch(2'b01, 5, 16'h0003);
        track("ignore", 2'b01, 5, 16'h0003, 2);
        chk("ignore_val", 32'(result), 32'h0060);
        @(negedge clk);
        chk("ignore_no_requeue", 32'(busy), 0);

        // Asynchronous abort in the middle of cycle 2 of a 6-step shift.
        launch(2'b01, 6, 16'h0001);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b1;
            chk("abort_no_done", 32'(done), 0);
        end
        launch(2'b01, 1, 16'h0001);
        track("post_abort", 2'b01, 1, 16'h0001, 0);
        chk("post_abort_val", 32'(result), 32'h0002);

        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom);
            ra = $urandom_range(0, (1 << AMT_W) - 1);
            rd = 16'($urandom);
            launch(ro, ra, rd);
            track("rand", ro, ra, rd, -1);
            held = model(ro, ra, rd);
            repeat ($urandom_range(1, 2)) begin
                @(negedge clk);
                chk("rand_idle_done", 32'(done), 0);
                chk("rand_hold", 32'(result), 32'(held));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
